// File: rtl/alu_issue.sv
// Issue stage: decodes RV32I fields into ALU operation/operands behind a two-entry skid buffer.
// Optional performance counters are built when ALU_ISSUE_PERF_CNT_EN is defined.
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [31:0]              issue_cnt,
    output logic [31:0]              stall_cnt
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = 'b0000;
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 'b0001;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 'b0010;
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 'b0011;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 'b0100;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = 'b0101;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 'b0110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = 'b0111;
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = 'b1000;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = 'b1100;
    localparam logic [OPCODE_LENGTH-1:0] OP_BAD = '1;

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]    dec_a, dec_b;
    logic                     dec_ill;
    logic                     is_r, is_shift, sra_sel;

    always_comb begin
        dec_op   = OP_BAD;
        dec_a    = '0;
        dec_b    = '0;
        dec_ill  = 1'b1;
        is_r     = opcode[5];
        is_shift = 1'b0;
        sra_sel  = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011: begin
                dec_a   = rs1_data;
                dec_b   = is_r ? rs2_data : imm;
                dec_ill = 1'b0;
                case (funct3)
                    3'b000: dec_op = (is_r && funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                    3'b001: begin dec_op = OP_SLL; is_shift = 1'b1; end
                    3'b010: dec_op = OP_SLT;
                    3'b100: dec_op = OP_XOR;
                    3'b101: begin
                        sra_sel  = is_r ? funct7[5] : imm[10];
                        dec_op   = sra_sel ? OP_SRA : OP_SRL;
                        is_shift = 1'b1;
                    end
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    default: begin
                        dec_op  = OP_BAD;
                        dec_a   = '0;
                        dec_b   = '0;
                        dec_ill = 1'b1;
                    end
                endcase
                // The ALU shifts by all of SrcB, so keep only shamt.
                if (is_shift) dec_b = {{(DATA_WIDTH-5){1'b0}}, dec_b[4:0]};
            end
            7'b0000011, 7'b0100011, 7'b1100111: begin
                dec_op  = OP_ADD;
                dec_a   = rs1_data;
                dec_b   = imm;
                dec_ill = 1'b0;
            end
            7'b1100011: begin
                if (funct3[2:1] != 2'b01) begin
                    dec_op  = funct3[2] ? OP_SLT : OP_EQ;
                    dec_a   = rs1_data;
                    dec_b   = rs2_data;
                    dec_ill = 1'b0;
                end
            end
            7'b0110111: begin
                dec_op  = OP_ADD;
                dec_b   = imm;
                dec_ill = 1'b0;
            end
            default: ;
        endcase
    end

    logic                     out_valid_q, out_valid_d;
    logic                     skid_valid_q, skid_valid_d;
    logic [OPCODE_LENGTH-1:0] out_op_q, out_op_d, skid_op_q, skid_op_d;
    logic [DATA_WIDTH-1:0]    out_a_q, out_a_d, skid_a_q, skid_a_d;
    logic [DATA_WIDTH-1:0]    out_b_q, out_b_d, skid_b_q, skid_b_d;
    logic                     out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic                     accept, drain;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_op_d     = out_op_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_ill_d    = out_ill_q;
        skid_op_d    = skid_op_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // Skid full implies in_ready was low, so no accept competes here.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
                out_op_d     = skid_op_q;
                out_a_d      = skid_a_q;
                out_b_d      = skid_b_q;
                out_ill_d    = skid_ill_q;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_op_d    = dec_op;
                out_a_d     = dec_a;
                out_b_d     = dec_b;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_op_d    = dec_op;
            skid_a_d     = dec_a;
            skid_b_d     = dec_b;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_op_q     <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_ill_q    <= 1'b0;
            skid_op_q    <= '0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_op_q     <= out_op_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_ill_q    <= out_ill_d;
            skid_op_q    <= skid_op_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign out_valid = out_valid_q;
    assign SrcA      = out_a_q;
    assign SrcB      = out_b_q;
    assign Operation = out_op_q;
    assign illegal   = out_ill_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && out_ready)  issue_cnt_d = issue_cnt_q + 32'd1;
        if (out_valid_q && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure, flush and counters.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, SrcA, SrcB, issue_cnt, stall_cnt;
    logic [3:0]  Operation;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .illegal(illegal), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        in_valid = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
        rs1_data = a; rs2_data = b; imm = im;
    endtask

    // Send one entry with out_ready high and check the decoded result a cycle later.
    task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [3:0] e_op, input logic [31:0] e_a,
                       input logic [31:0] e_b, input logic e_ill);
        drive(op, f3, f7, a, b, im);
        step();
        in_valid = 1'b0;
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".op"}, {28'd0, Operation}, {28'd0, e_op});
        chk({tag, ".a"}, SrcA, e_a);
        chk({tag, ".b"}, SrcB, e_b);
        chk({tag, ".ill"}, {31'd0, illegal}, {31'd0, e_ill});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        do_reset();

        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.srca", SrcA, 32'd0);
        chk("rst.srcb", SrcB, 32'd0);
        chk("rst.op", {28'd0, Operation}, 32'd0);
        chk("rst.ill", {31'd0, illegal}, 32'd0);
        chk("rst.issue", issue_cnt, 32'd0);
        chk("rst.stall", stall_cnt, 32'd0);

        vec("sub",   7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0,
            4'b0110, 32'd10, 32'd3, 1'b0);
        vec("add",   7'b0110011, 3'b000, 7'b0000000, 32'd7, 32'd9, 32'd0,
            4'b0010, 32'd7, 32'd9, 1'b0);
        vec("srai",  7'b0010011, 3'b101, 7'b0000000, 32'h80000000, 32'd0, 32'h00000405,
            4'b0111, 32'h80000000, 32'd5, 1'b0);
        vec("srli",  7'b0010011, 3'b101, 7'b0000000, 32'h80000000, 32'd0, 32'h00000005,
            4'b0101, 32'h80000000, 32'd5, 1'b0);
        vec("sll",   7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'h00000023, 32'd0,
            4'b0100, 32'd1, 32'd3, 1'b0);
        vec("sra",   7'b0110011, 3'b101, 7'b0100000, 32'hF0, 32'hFFFFFFE4, 32'd0,
            4'b0111, 32'hF0, 32'd4, 1'b0);
        vec("andi",  7'b0010011, 3'b111, 7'b0000000, 32'hFF, 32'd0, 32'hFFFFFFF0,
            4'b0000, 32'hFF, 32'hFFFFFFF0, 1'b0);
        vec("addi0", 7'b0010011, 3'b000, 7'b0100000, 32'd4, 32'd0, 32'h00000400,
            4'b0010, 32'd4, 32'h00000400, 1'b0);
        vec("lw",    7'b0000011, 3'b010, 7'b0000000, 32'h1000, 32'd0, 32'hFFFFFFFC,
            4'b0010, 32'h1000, 32'hFFFFFFFC, 1'b0);
        vec("lui",   7'b0110111, 3'b000, 7'b0000000, 32'd55, 32'd66, 32'h12345000,
            4'b0010, 32'd0, 32'h12345000, 1'b0);
        vec("beq",   7'b1100011, 3'b000, 7'b0000000, 32'd5, 32'd6, 32'd8,
            4'b1000, 32'd5, 32'd6, 1'b0);
        vec("bltu",  7'b1100011, 3'b110, 7'b0000000, 32'd5, 32'd6, 32'd8,
            4'b1100, 32'd5, 32'd6, 1'b0);
        vec("bf3_2", 7'b1100011, 3'b010, 7'b0000000, 32'd5, 32'd6, 32'd8,
            4'b1111, 32'd0, 32'd0, 1'b1);
        vec("ecall", 7'b1110011, 3'b000, 7'b0000000, 32'd5, 32'd6, 32'd8,
            4'b1111, 32'd0, 32'd0, 1'b1);
        step();
        chk("idle.out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: A to output, B to skid, C held upstream.
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0, 32'hA, 32'd0, 32'd0);
        step();
        chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
        drive(7'b0110011, 3'b000, 7'b0, 32'hB, 32'd0, 32'd0);
        step();
        chk("bp.rdy2", {31'd0, in_ready}, 32'd0);
        chk("bp.head1", SrcA, 32'hA);
        drive(7'b0110011, 3'b000, 7'b0, 32'hC, 32'd0, 32'd0);
        step();
        chk("bp.hold", SrcA, 32'hA);
        chk("bp.rdy3", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp.second", SrcA, 32'hB);
        chk("bp.vld2", {31'd0, out_valid}, 32'd1);
        chk("bp.rdy4", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp.third", SrcA, 32'hC);
        chk("bp.vld3", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full and a new entry offered.
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0, 32'h11, 32'd0, 32'd0);
        step();
        drive(7'b0110011, 3'b000, 7'b0, 32'h22, 32'd0, 32'd0);
        step();
        chk("fl.full", {31'd0, in_ready}, 32'd0);
        drive(7'b0110011, 3'b000, 7'b0, 32'h33, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("fl.no_accept", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

`ifdef ALU_ISSUE_PERF_CNT_EN
        chk("pc.keep", issue_cnt == 32'd0 ? 32'd0 : 32'd1, 32'd1);
        do_reset();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0, 32'd1, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b1;
        step();
        for (int i = 2; i <= 4; i++) begin
            drive(7'b0110011, 3'b000, 7'b0, i, 32'd0, 32'd0);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pc.issue", issue_cnt, 32'd4);
        chk("pc.stall", stall_cnt, 32'd2);
        force dut.issue_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.issue_cnt_q;
        drive(7'b0110011, 3'b000, 7'b0, 32'd9, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        chk("pc.preload", issue_cnt, 32'hFFFFFFFF);
        step();
        chk("pc.wrap", issue_cnt, 32'd0);
`else
        chk("pc.issue_tied", issue_cnt, 32'd0);
        chk("pc.stall_tied", stall_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
